// File: rtl/rsa_msg_loader_if.sv
// Handshake and data bundle between the byte-stream source, the RSA loader and the
// encryptor.
interface rsa_msg_loader_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 16
);
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [DATA_W-1:0] n;
  logic              enc_done;
  logic [DATA_W-1:0] message;
  logic              start_bit;
  logic              busy;
  logic              msg_err;
  logic [CNT_W-1:0]  blk_count;

  modport slave (
    input  in_byte, in_valid, flush, n, enc_done,
    output in_ready, message, start_bit, busy, msg_err, blk_count
  );

  modport master (
    output in_byte, in_valid, flush, n, enc_done,
    input  in_ready, message, start_bit, busy, msg_err, blk_count
  );
endinterface

// File: rtl/rsa_msg_loader.sv
// Packs a byte stream MSB-first into DATA_W-bit blocks, range-checks each block against
// the modulus n, and hands passing blocks to the RSA encryptor.
module rsa_msg_loader #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  rsa_msg_loader_if.slave   bus
);
  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned BcW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [1:0] StCollect = 2'd0;
  localparam logic [1:0] StCheck   = 2'd1;
  localparam logic [1:0] StIssue   = 2'd2;
  localparam logic [1:0] StWait    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [BcW-1:0]    bytecnt_q, bytecnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] message_q, message_d;
  logic [CNT_W-1:0]  blk_count_q, blk_count_d;
  // Holds in_ready low until the first clock edge after reset is released.
  logic              rdy_en_q;
  logic              accept;
  logic              reject;

  assign bus.in_ready  = rdy_en_q && (state_q == StCollect);
  assign bus.start_bit = (state_q == StIssue);
  assign bus.busy      = (state_q != StCollect);
  assign bus.msg_err   = reject;
  assign bus.message   = message_q;
  assign bus.blk_count = blk_count_q;

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d     = state_q;
    bytecnt_d   = bytecnt_q;
    shreg_d     = shreg_q;
    message_d   = message_q;
    blk_count_d = blk_count_q;
    reject      = 1'b0;
    unique case (state_q)
      StCollect: begin
        if (bus.flush) begin
          bytecnt_d = '0;
          shreg_d   = '0;
        end else if (accept) begin
          shreg_d = {shreg_q[DATA_W-9:0], bus.in_byte};
          if (bytecnt_q == BcW'(NBYTES - 1)) begin
            bytecnt_d = '0;
            state_d   = StCheck;
          end else begin
            bytecnt_d = bytecnt_q + BcW'(1);
          end
        end
      end
      StCheck: begin
        if ((bus.n != '0) && (shreg_q < bus.n)) begin
          message_d = shreg_q;
          state_d   = StIssue;
        end else begin
          reject  = 1'b1;
          shreg_d = '0;
          state_d = StCollect;
        end
      end
      StIssue: begin
        blk_count_d = blk_count_q + CNT_W'(1);
        state_d     = StWait;
      end
      StWait: begin
        if (bus.enc_done) state_d = StCollect;
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StCollect;
      bytecnt_q   <= '0;
      shreg_q     <= '0;
      message_q   <= '0;
      blk_count_q <= '0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bytecnt_q   <= bytecnt_d;
      shreg_q     <= shreg_d;
      message_q   <= message_d;
      blk_count_q <= blk_count_d;
      rdy_en_q    <= 1'b1;
    end
  end
endmodule
